// File: rtl/adder_exhaustive_checker_if.sv
// Adder-under-test bus: the checker drives the operands and receives the result.
// The master side is the checker; the slave side is the adder being signed off.
interface adder_exhaustive_checker_if #(
    parameter int WIDTH = 4
);
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             c_in;
    logic [WIDTH-1:0] dut_sum;
    logic             dut_c_out;

    modport master (
        output a,
        output b,
        output c_in,
        input  dut_sum,
        input  dut_c_out
    );

    modport slave (
        input  a,
        input  b,
        input  c_in,
        output dut_sum,
        output dut_c_out
    );
endinterface

// File: rtl/adder_exhaustive_checker.sv
// Exhaustive sign-off engine for N-bit adders: walks every {c_in, a, b} vector,
// compares the returned {c_out, sum} to a golden sum and records the results.
module adder_exhaustive_checker #(
    parameter int WIDTH        = 4,
    parameter bit STOP_ON_FAIL = 1'b0
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    adder_exhaustive_checker_if.master  adder,
    output logic                        busy,
    output logic                        done,
    output logic                        pass,
    output logic [2*WIDTH+1:0]          err_count,
    output logic                        fail_seen,
    output logic [2*WIDTH:0]            first_fail
);

    localparam int IDX_W = 2 * WIDTH + 1;
    localparam int ERR_W = 2 * WIDTH + 2;
    localparam int SUM_W = WIDTH + 1;

    localparam logic [IDX_W-1:0] IDX_ONE = IDX_W'(1);
    localparam logic [ERR_W-1:0] ERR_ONE = ERR_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DRIVE,
        ST_CHECK,
        ST_DONE
    } state_e;

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [ERR_W-1:0]   err_count_q, err_count_d;
    logic               fail_seen_q, fail_seen_d;
    logic [IDX_W-1:0]   first_fail_q, first_fail_d;

    logic [WIDTH-1:0]   op_a;
    logic [WIDTH-1:0]   op_b;
    logic               op_c_in;
    logic [SUM_W-1:0]   exp_result;
    logic [SUM_W-1:0]   got_result;
    logic               mismatch;
    logic               last_vec;

    // The vector index is the operand bundle itself, so b steps fastest.
    assign op_c_in = idx_q[IDX_W-1];
    assign op_a    = idx_q[2*WIDTH-1:WIDTH];
    assign op_b    = idx_q[WIDTH-1:0];

    assign exp_result = SUM_W'(op_a) + SUM_W'(op_b) + SUM_W'(op_c_in);
    assign got_result = {adder.dut_c_out, adder.dut_sum};
    assign mismatch   = (got_result != exp_result);
    assign last_vec   = (idx_q == '1);

    // NOTE: every signal written here gets a default first, so no path leaves
    // one unassigned and no latch is inferred.
    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        err_count_d  = err_count_q;
        fail_seen_d  = fail_seen_q;
        first_fail_d = first_fail_q;

        unique case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    idx_d        = '0;
                    err_count_d  = '0;
                    fail_seen_d  = 1'b0;
                    first_fail_d = '0;
                    state_d      = ST_DRIVE;
                end
            end

            ST_DRIVE: begin
                state_d = ST_CHECK;
            end

            ST_CHECK: begin
                if (mismatch) begin
                    err_count_d = err_count_q + ERR_ONE;
                    if (!fail_seen_q) begin
                        fail_seen_d  = 1'b1;
                        first_fail_d = idx_q;
                    end
                end

                // The last vector always ends the run, so idx never wraps.
                if (last_vec || (STOP_ON_FAIL && mismatch)) begin
                    state_d = ST_DONE;
                end else begin
                    idx_d   = idx_q + IDX_ONE;
                    state_d = ST_DRIVE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            idx_q        <= '0;
            err_count_q  <= '0;
            fail_seen_q  <= 1'b0;
            first_fail_q <= '0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            err_count_q  <= err_count_d;
            fail_seen_q  <= fail_seen_d;
            first_fail_q <= first_fail_d;
        end
    end

    assign adder.a    = op_a;
    assign adder.b    = op_b;
    assign adder.c_in = op_c_in;

    assign busy       = (state_q == ST_DRIVE) || (state_q == ST_CHECK);
    assign done       = (state_q == ST_DONE);
    assign pass       = done && (err_count_q == '0);
    assign err_count  = err_count_q;
    assign fail_seen  = fail_seen_q;
    assign first_fail = first_fail_q;

endmodule

// File: tb/tb_adder_exhaustive_checker.sv
// Bench for adder_exhaustive_checker: two checker instances (run-to-end and
// stop-on-fail) driving a behavioural adder with selectable faults.
module tb_adder_exhaustive_checker;

    localparam int W = 4;
    localparam int NVEC = 1 << (2 * W + 1);
    localparam int FULL_CYCLES = 2 * NVEC;

    typedef struct {
        int          cycles;
        logic [31:0] err;
        logic [31:0] ff;
        logic        fs;
        logic        pass;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    logic start0, start1;
    int   fault;
    int   sel;
    int   n_checks = 0;
    int   n_errors = 0;
    exp_t sb_q[$];

    logic             busy0, done0, pass0, fs0, busy1, done1, pass1, fs1;
    logic [2*W+1:0]   err0, err1;
    logic [2*W:0]     ff0, ff1;

    logic             o_busy, o_done, o_pass, o_fs;
    logic [31:0]      o_err, o_ff, o_ops;

    adder_exhaustive_checker_if #(.WIDTH(W)) if0 ();
    adder_exhaustive_checker_if #(.WIDTH(W)) if1 ();

    adder_exhaustive_checker #(.WIDTH(W), .STOP_ON_FAIL(1'b0)) u_run (
        .clk(clk), .rst(rst), .start(start0), .adder(if0),
        .busy(busy0), .done(done0), .pass(pass0),
        .err_count(err0), .fail_seen(fs0), .first_fail(ff0)
    );

    adder_exhaustive_checker #(.WIDTH(W), .STOP_ON_FAIL(1'b1)) u_stop (
        .clk(clk), .rst(rst), .start(start1), .adder(if1),
        .busy(busy1), .done(done1), .pass(pass1),
        .err_count(err1), .fail_seen(fs1), .first_fail(ff1)
    );

    always #5 clk = ~clk;

    // Behavioural adder under test: 0 correct, 1 c_out stuck at 0, 2 sum[0] inverted.
    function automatic logic [W:0] adder_out(input int f, input logic [W-1:0] a,
                                             input logic [W-1:0] b, input logic ci);
        logic [W:0] r;
        r = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, ci};
        if (f == 1) r[W] = 1'b0;
        if (f == 2) r[0] = ~r[0];
        return r;
    endfunction

    always_comb {if0.dut_c_out, if0.dut_sum} = adder_out(fault, if0.a, if0.b, if0.c_in);
    always_comb {if1.dut_c_out, if1.dut_sum} = adder_out(fault, if1.a, if1.b, if1.c_in);

    always_comb begin
        o_busy = (sel == 1) ? busy1 : busy0;
        o_done = (sel == 1) ? done1 : done0;
        o_pass = (sel == 1) ? pass1 : pass0;
        o_fs   = (sel == 1) ? fs1   : fs0;
        o_err  = (sel == 1) ? 32'(err1) : 32'(err0);
        o_ff   = (sel == 1) ? 32'(ff1)  : 32'(ff0);
        o_ops  = (sel == 1) ? 32'({if1.c_in, if1.a, if1.b}) : 32'({if0.c_in, if0.a, if0.b});
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic drive_start(input logic v);
        if (sel == 1) start1 = v;
        else          start0 = v;
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_busy"}, 32'(o_busy), 32'd0);
        check({tag, "_done"}, 32'(o_done), 32'd0);
        check({tag, "_pass"}, 32'(o_pass), 32'd0);
        check({tag, "_err"},  o_err, 32'd0);
        check({tag, "_fs"},   32'(o_fs), 32'd0);
        check({tag, "_ff"},   o_ff, 32'd0);
        check({tag, "_ops"},  o_ops, 32'd0);
    endtask

    // Predicts one run, pushes it to the scoreboard, then runs the DUT and
    // pops the prediction when done rises.
    task automatic run(input int s, input int f, input int mid_start);
        exp_t e;
        exp_t got;
        int   c;
        logic [W:0] truth;
        e = '{cycles: FULL_CYCLES, err: 32'd0, ff: 32'd0, fs: 1'b0, pass: 1'b0};
        for (int v = 0; v < NVEC; v++) begin
            logic [W-1:0] va, vb;
            logic         vc;
            va = W'(v >> W);
            vb = W'(v);
            vc = (v >= (1 << (2 * W)));
            truth = W'(0) + (W + 1)'(va) + (W + 1)'(vb) + (W + 1)'(vc);
            if (adder_out(f, va, vb, vc) !== truth) begin
                e.err++;
                if (!e.fs) begin
                    e.fs = 1'b1;
                    e.ff = 32'(v);
                end
                if (s == 1) begin
                    e.cycles = 2 * v + 2;
                    break;
                end
            end
        end
        e.pass = (e.err == 0);

        sel   = s;
        fault = f;
        sb_q.push_back(e);
        @(negedge clk) drive_start(1'b1);
        @(negedge clk) drive_start(1'b0);

        check("accept_busy", 32'(o_busy), 32'd1);
        check("accept_done", 32'(o_done), 32'd0);
        check("accept_pass", 32'(o_pass), 32'd0);
        check("accept_err",  o_err, 32'd0);
        check("accept_fs",   32'(o_fs), 32'd0);

        c = 0;
        while (!o_done && c < FULL_CYCLES + 50) begin
            if (c == 63 || c == 511 || c == FULL_CYCLES - 1) begin
                check("vector_order", o_ops, 32'(c >> 1));
                check("busy_in_run", 32'(o_busy), 32'd1);
            end
            drive_start(c == mid_start);
            @(negedge clk);
            c++;
        end
        drive_start(1'b0);

        got = sb_q.pop_front();
        check("done_seen",   32'(o_done), 32'd1);
        check("done_cycle",  32'(c), 32'(got.cycles));
        check("done_busy",   32'(o_busy), 32'd0);
        check("result_pass", 32'(o_pass), 32'(got.pass));
        check("result_err",  o_err, got.err);
        check("result_fs",   32'(o_fs), 32'(got.fs));
        check("result_ff",   o_ff, got.ff);
    endtask

    initial begin
        rst    = 1'b1;
        start0 = 1'b0;
        start1 = 1'b0;
        fault  = 0;
        sel    = 0;
        repeat (2) @(negedge clk);
        check_idle_outputs("reset0");
        sel = 1;
        #0 check_idle_outputs("reset1");
        rst = 1'b0;
        @(negedge clk);

        run(0, 0, -1);      // correct adder
        run(0, 1, 500);     // c_out stuck at 0, stray start mid-run
        run(1, 1, -1);      // same fault, stop on first failure
        run(0, 2, -1);      // sum[0] inverted
        run(0, 0, -1);      // restart from DONE clears the failing results

        // Abort a run with reset at cycle 300.
        sel = 0;
        @(negedge clk) start0 = 1'b1;
        @(negedge clk) start0 = 1'b0;
        repeat (300) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_idle_outputs("abort");
        rst = 1'b0;
        @(negedge clk);
        run(0, 0, -1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
